// File: rtl/decode_stage.sv
// decode_stage: registered instruction-decode pipeline stage.
// Takes one instruction per valid/ready handshake and presents one registered
// control bundle per instruction. It applies back-pressure while the bundle is
// held, stalls on load-use hazards, discards the held bundle on flush, and
// stops accepting instructions after a HALT until resume is pulsed.
// Optional build macro DECODE_STAGE_STATS_EN adds saturating retired/stall
// counters and their output ports.
module decode_stage #(
  parameter int NUM_REGS    = 16,
  parameter int INSTR_WIDTH = 9,
  parameter int REG_WIDTH   = 8,
  parameter int OP_WIDTH    = 4,
  parameter int RS_BASE     = 4,
  parameter int RD_BASE     = 8,
  parameter int ACC_REG     = 12,
  localparam int RA         = $clog2(NUM_REGS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [INSTR_WIDTH-1:0] instruction,
  input  logic                   flush,
  input  logic                   resume,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OP_WIDTH-1:0]    alu_op,
  output logic [RA-1:0]          rs_addr,
  output logic [RA-1:0]          rt_addr,
  output logic [RA-1:0]          rd_addr,
  output logic [REG_WIDTH-1:0]   imm,
  output logic                   reg_write,
  output logic                   car_write,
  output logic                   sel_imm,
  output logic                   jump,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic                   mem2reg,
  output logic                   halted
`ifdef DECODE_STAGE_STATS_EN
  ,
  output logic [15:0]            retired_count,
  output logic [15:0]            stall_count
`endif
);

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_e;

  // Control bundle presented downstream.
  typedef struct packed {
    logic [OP_WIDTH-1:0]  alu_op;
    logic [RA-1:0]        rs;
    logic [RA-1:0]        rt;
    logic [RA-1:0]        rd;
    logic [REG_WIDTH-1:0] imm;
    logic                 reg_write;
    logic                 car_write;
    logic                 sel_imm;
    logic                 jump;
    logic                 mem_read;
    logic                 mem_write;
    logic                 mem2reg;
  } bundle_t;

  // Decode result: the bundle plus which source fields are real register reads
  // (needed by hazard detection) and whether this is a HALT.
  typedef struct packed {
    bundle_t b;
    logic    rs_used;
    logic    rt_used;
    logic    is_halt;
  } dec_t;

  // Pure decode of one instruction word; unlisted fields stay 0.
  function automatic dec_t decode(input logic [INSTR_WIDTH-1:0] instr);
    dec_t       d;
    logic [2:0] opc;
    logic [1:0] f54;
    logic [1:0] f32;
    logic [1:0] f10;
    opc = instr[INSTR_WIDTH-1 -: 3];
    f54 = instr[5:4];
    f32 = instr[3:2];
    f10 = instr[1:0];
    d   = '0;
    case (opc)
      3'b000: begin
        d.rs_used = 1'b1;
        d.rt_used = 1'b1;
        if (f10 != 2'b11) begin
          // AND / SLT / OR into the accumulator register
          d.b.alu_op    = OP_WIDTH'(f10);
          d.b.rs        = RA'(f54) + RA'(RS_BASE);
          d.b.rt        = RA'(f32);
          d.b.rd        = RA'(ACC_REG);
          d.b.reg_write = 1'b1;
        end else begin
          // BEQ
          d.b.alu_op = OP_WIDTH'(7);
          d.b.rs     = RA'(f54);
          d.b.rt     = RA'(f32) + RA'(RD_BASE);
        end
      end
      3'b001: begin
        d.rs_used = 1'b1;
        case (f10)
          2'b00: begin // LW
            d.b.alu_op    = OP_WIDTH'(6);
            d.b.rs        = RA'(f54) + RA'(RS_BASE);
            d.b.rd        = RA'(f32);
            d.b.reg_write = 1'b1;
            d.b.mem_read  = 1'b1;
            d.b.mem2reg   = 1'b1;
          end
          2'b01: begin // SW
            d.rt_used     = 1'b1;
            d.b.alu_op    = OP_WIDTH'(6);
            d.b.rs        = RA'(f54) + RA'(RS_BASE);
            d.b.rt        = RA'(f32);
            d.b.mem_write = 1'b1;
          end
          2'b10: begin // INC
            d.b.alu_op  = OP_WIDTH'(4);
            d.b.rs      = RA'(instr[5:2]);
            d.b.rd      = RA'(instr[5:2]);
            d.b.imm     = REG_WIDTH'(1);
            d.b.sel_imm = 1'b1;
          end
          default: begin // NOT
            d.b.alu_op = OP_WIDTH'(3);
            d.b.rs     = RA'(instr[5:2]);
            d.b.rd     = RA'(instr[5:2]);
          end
        endcase
      end
      3'b010, 3'b100: begin // ADD / SUB
        d.rs_used     = 1'b1;
        d.rt_used     = 1'b1;
        d.b.alu_op    = (opc == 3'b010) ? OP_WIDTH'(4) : OP_WIDTH'(5);
        d.b.rs        = RA'(f54) + RA'(RS_BASE);
        d.b.rt        = RA'(f32);
        d.b.rd        = RA'(f10) + RA'(RD_BASE);
        d.b.reg_write = 1'b1;
        d.b.car_write = 1'b1;
      end
      3'b011: begin // ADDI
        d.rs_used   = 1'b1;
        d.b.alu_op  = OP_WIDTH'(4);
        d.b.rs      = RA'(f32);
        d.b.rd      = RA'(f54) + RA'(RD_BASE);
        d.b.imm     = REG_WIDTH'(f10);
        d.b.sel_imm = 1'b1;
      end
      3'b101: begin // TR
        d.rs_used     = 1'b1;
        d.b.alu_op    = OP_WIDTH'(6);
        d.b.rs        = RA'(instr[2:0]) + RA'(5);
        d.b.rd        = RA'(instr[5:3]) + RA'(1);
        d.b.reg_write = 1'b1;
      end
      3'b110: begin // JR
        d.b.alu_op = OP_WIDTH'(6);
        d.b.imm    = REG_WIDTH'(instr[5:0]);
        d.b.jump   = 1'b1;
      end
      default: begin
        if (f10 != 2'b11) begin
          // SRL / SRA / SLL, in place on rs
          d.rs_used     = 1'b1;
          d.rt_used     = 1'b1;
          d.b.alu_op    = OP_WIDTH'(8) + OP_WIDTH'(f10);
          d.b.rs        = RA'(f54) + RA'(RS_BASE);
          d.b.rd        = RA'(f54) + RA'(RS_BASE);
          d.b.rt        = RA'(f32);
          d.b.reg_write = 1'b1;
          d.b.car_write = 1'b1;
        end else begin
          // HALT: empty bundle
          d.is_halt = 1'b1;
        end
      end
    endcase
    return d;
  endfunction

  state_e  state_q, state_d;
  logic    out_valid_q, out_valid_d;
  bundle_t bundle_q, bundle_d;
  dec_t    dec_in;
  logic    hazard;
  logic    accept;
  logic    take;

  // Decode the incoming word and detect a load-use dependency on the held LW.
  always_comb begin
    dec_in = decode(instruction);
    hazard = out_valid_q & bundle_q.mem_read &
             ((dec_in.rs_used & (dec_in.b.rs == bundle_q.rd)) |
              (dec_in.rt_used & (dec_in.b.rt == bundle_q.rd)));
  end

  // Handshake: ready only when running, the output slot frees up and no hazard.
  always_comb begin
    in_ready = rst_n & (state_q == ST_RUN) & (~out_valid_q | out_ready) & ~hazard;
    accept   = in_valid & in_ready;
    take     = accept & ~flush;
  end

  // Next-state for the output slot and run/halt state; flush beats accept.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    out_valid_d = out_valid_q;
    bundle_d    = bundle_q;
    state_d     = state_q;
    if (flush) begin
      out_valid_d = 1'b0;
      bundle_d    = '0;
    end else if (take) begin
      out_valid_d = 1'b1;
      bundle_d    = dec_in.b;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
      bundle_d    = '0;
    end
    if (take && dec_in.is_halt) begin
      state_d = ST_HALTED;
    end else if ((state_q == ST_HALTED) && resume) begin
      state_d = ST_RUN;
    end
  end

  // Pipeline registers; reset discards the bundle immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state_q     <= ST_RUN;
      out_valid_q <= 1'b0;
      bundle_q    <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      bundle_q    <= bundle_d;
    end
  end

  assign out_valid = out_valid_q;
  assign alu_op    = bundle_q.alu_op;
  assign rs_addr   = bundle_q.rs;
  assign rt_addr   = bundle_q.rt;
  assign rd_addr   = bundle_q.rd;
  assign imm       = bundle_q.imm;
  assign reg_write = bundle_q.reg_write;
  assign car_write = bundle_q.car_write;
  assign sel_imm   = bundle_q.sel_imm;
  assign jump      = bundle_q.jump;
  assign mem_read  = bundle_q.mem_read;
  assign mem_write = bundle_q.mem_write;
  assign mem2reg   = bundle_q.mem2reg;
  assign halted    = (state_q == ST_HALTED);

`ifdef DECODE_STAGE_STATS_EN
  logic [15:0] retired_q, retired_d;
  logic [15:0] stall_q, stall_d;

  // Saturating event counters.
  always_comb begin
    retired_d = retired_q;
    stall_d   = stall_q;
    if (out_valid_q && out_ready && (retired_q != 16'hFFFF)) begin
      retired_d = retired_q + 16'd1;
    end
    if (in_valid && !in_ready && !halted && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_q <= '0;
      stall_q   <= '0;
    end else begin
      retired_q <= retired_d;
      stall_q   <= stall_d;
    end
  end

  assign retired_count = retired_q;
  assign stall_count   = stall_q;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed and randomized checks of decode_stage against a
// cycle-level reference model built from the instruction table.
module tb_decode_stage;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [8:0] instruction;
  logic       flush;
  logic       resume;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] alu_op;
  logic [3:0] rs_addr, rt_addr, rd_addr;
  logic [7:0] imm;
  logic       reg_write, car_write, sel_imm, jump, mem_read, mem_write, mem2reg;
  logic       halted;
`ifdef DECODE_STAGE_STATS_EN
  logic [15:0] retired_count, stall_count;
  int          m_retired, m_stall;
`endif

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .flush(flush), .resume(resume),
    .out_valid(out_valid), .out_ready(out_ready), .alu_op(alu_op),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr), .imm(imm),
    .reg_write(reg_write), .car_write(car_write), .sel_imm(sel_imm),
    .jump(jump), .mem_read(mem_read), .mem_write(mem_write),
    .mem2reg(mem2reg), .halted(halted)
`ifdef DECODE_STAGE_STATS_EN
    , .retired_count(retired_count), .stall_count(stall_count)
`endif
  );

  // Expected decode of one instruction, in plain integers.
  typedef struct {
    int alu, rs, rt, rd, imm;
    bit rw, cw, si, j, mr, mw, m2r;
    bit halt, use_rs, use_rt;
  } exp_t;

  int   n_pass  = 0;
  int   n_total = 0;
  int   n_fail  = 0;
  bit   m_valid;
  bit   m_halted;
  exp_t m_b;

  function automatic exp_t ref_decode(input logic [8:0] i);
    exp_t e;
    int   op, a, b, c;
    e  = '{default: 0};
    op = int'(i[8:6]);
    a  = int'(i[5:4]);
    b  = int'(i[3:2]);
    c  = int'(i[1:0]);
    case (op)
      0: begin
        e.use_rs = 1; e.use_rt = 1;
        if (c < 3) begin
          e.alu = c; e.rs = (a + 4) % 16; e.rt = b; e.rd = 12; e.rw = 1;
        end else begin
          e.alu = 7; e.rs = a; e.rt = (b + 8) % 16;
        end
      end
      1: begin
        e.use_rs = 1;
        case (c)
          0: begin e.alu = 6; e.rs = (a + 4) % 16; e.rd = b; e.rw = 1; e.mr = 1; e.m2r = 1; end
          1: begin e.alu = 6; e.rs = (a + 4) % 16; e.rt = b; e.mw = 1; e.use_rt = 1; end
          2: begin e.alu = 4; e.rs = int'(i[5:2]); e.rd = e.rs; e.imm = 1; e.si = 1; end
          default: begin e.alu = 3; e.rs = int'(i[5:2]); e.rd = e.rs; end
        endcase
      end
      2, 4: begin
        e.alu = (op == 2) ? 4 : 5;
        e.rs = (a + 4) % 16; e.rt = b; e.rd = (c + 8) % 16;
        e.rw = 1; e.cw = 1; e.use_rs = 1; e.use_rt = 1;
      end
      3: begin e.alu = 4; e.rs = b; e.rd = (a + 8) % 16; e.imm = c; e.si = 1; e.use_rs = 1; end
      5: begin
        e.alu = 6; e.rs = (int'(i[2:0]) + 5) % 16; e.rd = (int'(i[5:3]) + 1) % 16;
        e.rw = 1; e.use_rs = 1;
      end
      6: begin e.alu = 6; e.imm = int'(i[5:0]); e.j = 1; end
      default: begin
        if (c < 3) begin
          e.alu = 8 + c; e.rs = (a + 4) % 16; e.rd = e.rs; e.rt = b;
          e.rw = 1; e.cw = 1; e.use_rs = 1; e.use_rt = 1;
        end else begin
          e.halt = 1;
        end
      end
    endcase
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".out_valid"}, out_valid, m_valid);
    check({tag, ".halted"}, halted, m_halted);
    if (m_valid) begin
      check({tag, ".alu_op"}, alu_op, m_b.alu);
      check({tag, ".rs"}, rs_addr, m_b.rs);
      check({tag, ".rt"}, rt_addr, m_b.rt);
      check({tag, ".rd"}, rd_addr, m_b.rd);
      check({tag, ".imm"}, imm, m_b.imm);
      check({tag, ".ctrl"}, {reg_write, car_write, sel_imm, jump, mem_read, mem_write, mem2reg},
            {m_b.rw, m_b.cw, m_b.si, m_b.j, m_b.mr, m_b.mw, m_b.m2r});
    end
`ifdef DECODE_STAGE_STATS_EN
    check({tag, ".retired"}, retired_count, m_retired);
    check({tag, ".stalls"}, stall_count, m_stall);
`endif
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".in_ready"}, in_ready, 0);
    check({tag, ".out_valid"}, out_valid, 0);
    check({tag, ".halted"}, halted, 0);
    check({tag, ".bundle"}, {alu_op, rs_addr, rt_addr, rd_addr, imm}, 0);
    check({tag, ".ctrl"}, {reg_write, car_write, sel_imm, jump, mem_read, mem_write, mem2reg}, 0);
  endtask

  task automatic reset_model();
    m_valid  = 0;
    m_halted = 0;
    m_b      = '{default: 0};
`ifdef DECODE_STAGE_STATS_EN
    m_retired = 0;
    m_stall   = 0;
`endif
  endtask

  // One clock cycle: drive inputs just after an edge, check ready, clock, check outputs.
  task automatic step(input string tag, input bit v, input logic [8:0] ins,
                      input bit ordy, input bit fl, input bit res);
    exp_t d;
    bit   haz, exp_ready, acc;
    in_valid    = v;
    instruction = ins;
    out_ready   = ordy;
    flush       = fl;
    resume      = res;
    #1;
    d   = ref_decode(ins);
    haz = m_valid && m_b.mr && ((d.use_rs && d.rs == m_b.rd) || (d.use_rt && d.rt == m_b.rd));
    exp_ready = !m_halted && (!m_valid || ordy) && !haz;
    check({tag, ".in_ready"}, in_ready, exp_ready);
    acc = v && exp_ready;
`ifdef DECODE_STAGE_STATS_EN
    if (m_valid && ordy && m_retired < 65535) m_retired++;
    if (v && !exp_ready && !m_halted && m_stall < 65535) m_stall++;
`endif
    @(posedge clk);
    #1;
    if (fl) m_valid = 0;
    else if (acc) begin m_valid = 1; m_b = d; end
    else if (ordy) m_valid = 0;
    if (acc && !fl && d.halt) m_halted = 1;
    else if (res) m_halted = 0;
    check_outputs(tag);
  endtask

  localparam logic [8:0] I_ADD  = 9'b010_01_10_11;
  localparam logic [8:0] I_SUB  = 9'b100_10_01_00;
  localparam logic [8:0] I_LW   = 9'b001_00_01_00;
  localparam logic [8:0] I_AND  = 9'b000_00_01_00;
  localparam logic [8:0] I_INC  = 9'b001_0110_10;
  localparam logic [8:0] I_HALT = 9'b111_000011;

  initial begin
    logic [8:0] rnd_ins;
    rst_n = 1'b0; in_valid = 0; instruction = '0; out_ready = 0; flush = 0; resume = 0;
    reset_model();
    #3;
    check_reset("reset");
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ADD decode
    step("add", 1, I_ADD, 1, 0, 0);
    check("add.alu_op", alu_op, 4);
    check("add.rs", rs_addr, 5);
    check("add.rt", rt_addr, 2);
    check("add.rd", rd_addr, 11);
    check("add.rw_cw", {reg_write, car_write}, 2'b11);
    step("idle", 0, '0, 1, 0, 0);

    // Load-use: AND reads LW destination r1 -> one bubble
    step("lw", 1, I_LW, 1, 0, 0);
    check("lw.mem_read", mem_read, 1);
    step("lu_stall", 1, I_AND, 1, 0, 0);
    check("lu_bubble.out_valid", out_valid, 0);
    step("lu_accept", 1, I_AND, 1, 0, 0);
    check("lu_and.out_valid", out_valid, 1);
    check("lu_and.rd", rd_addr, 12);
    step("idle", 0, '0, 1, 0, 0);

    // Hold for three cycles, then consume
    step("hold_load", 1, I_SUB, 1, 0, 0);
    for (int k = 0; k < 3; k++) begin
      step("hold", 1, I_ADD, 0, 0, 0);
      check("hold.in_ready", in_ready, 0);
      check("hold.alu_op", alu_op, 5);
    end
    step("consume", 0, '0, 1, 0, 0);
    check("consume.out_valid", out_valid, 0);
    check("consume.in_ready", in_ready, 1);

    // HALT, ten blocked cycles, resume
    step("halt", 1, I_HALT, 1, 0, 0);
    check("halt.halted", halted, 1);
    check("halt.out_valid", out_valid, 1);
    for (int k = 0; k < 10; k++) begin
      step("halted", 1, I_ADD, 1, 0, 0);
      check("halted.in_ready", in_ready, 0);
    end
    step("resume", 0, '0, 1, 0, 1);
    check("resume.halted", halted, 0);
    check("resume.in_ready", in_ready, 1);

    // HALT accepted with resume in the same cycle: halt wins
    step("halt_res", 1, I_HALT, 1, 0, 1);
    check("halt_res.halted", halted, 1);
    step("resume2", 0, '0, 1, 0, 1);

    // Flush with accept of INC drops it
    step("flush_inc", 1, I_INC, 1, 1, 0);
    check("flush_inc.out_valid", out_valid, 0);
    step("idle", 0, '0, 1, 0, 0);

    // Flush does not clear halted
    step("halt_hold", 1, I_HALT, 0, 0, 0);
    step("halt_flush", 0, '0, 0, 1, 0);
    check("halt_flush.out_valid", out_valid, 0);
    check("halt_flush.halted", halted, 1);
    step("resume3", 0, '0, 1, 0, 1);

    // Reset in the middle of a stall
    step("stall_load", 1, I_ADD, 0, 0, 0);
    step("stall", 1, I_SUB, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("mid_reset");
    reset_model();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    step("post_reset", 1, I_ADD, 1, 0, 0);
    check("post_reset.rd", rd_addr, 11);

    // Randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      rnd_ins = 9'($urandom);
      if ($urandom_range(0, 3) == 0) rnd_ins = {3'b001, 4'($urandom), 2'b00};
      step("rnd", $urandom_range(0, 9) < 7, rnd_ins, $urandom_range(0, 9) < 7,
           $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered, parametrised instruction-decode pipeline stage; successor to the combinational 9-bit decoder.
- Sits between instruction fetch and register-file/ALU issue.
- Accepts instructions via valid/ready handshake and presents one registered control bundle per instruction.
- Adds stall back-pressure, load-use hazard detection, flush-on-jump and a sticky halt state.

Parameters:
- NUM_REGS, 16, register-file entries; address width RA = $clog2(NUM_REGS).
- INSTR_WIDTH, 9, instruction width; opcode = top 3 bits, fields below are the low 6 bits.
- REG_WIDTH, 8, immediate/data width.
- OP_WIDTH, 4, ALU op code width.
- RS_BASE, 4, offset added to 2-bit rs field.
- RD_BASE, 8, offset added to 2-bit rd field.
- ACC_REG, 12, implicit destination for AND/SLT/OR.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  instruction present.
- in_ready  out  1  stage accepts instruction this cycle.
- instruction  in  INSTR_WIDTH  instruction word.
- flush  in  1  discard held bundle (taken jump/branch downstream).
- resume  in  1  leave HALTED state.
- out_valid  out  1  bundle valid.
- out_ready  in  1  downstream consumes bundle.
- alu_op  out  OP_WIDTH  ALU operation.
- rs_addr, rt_addr, rd_addr  out  RA each  register addresses.
- imm  out  REG_WIDTH  immediate (zero-extended).
- reg_write, car_write, sel_imm, jump, mem_read, mem_write, mem2reg  out  1 each  control.
- halted  out  1  sticky halt status.

Behaviour:
- Reset (async, rst_n=0): all outputs 0, state RUN, out_valid=0, halted=0; in_ready is 0 while rst_n=0.
- States:
  - RUN: in_ready = !out_valid | out_ready, gated by no hazard.
  - HALTED: in_ready=0; resume=1 returns to RUN the next cycle.
- Accept (in_valid & in_ready):
  - Bundle registers one cycle later, out_valid=1. Latency 1 cycle.
  - Unknown fields are driven 0, never X.
- Hold: out_valid & !out_ready holds the bundle stable and in_ready=0.
- Consume without accept: out_ready & !accept clears out_valid.
- Decode, with f54=instr[5:4], f32=instr[3:2], f10=instr[1:0]:
  - AND/SLT/OR (000, sub 00/01/10): alu 0/1/2; rs=f54+RS_BASE; rt=f32; rd=ACC_REG; reg_write.
  - BEQ (000, sub 11): alu 7; rs=f54; rt=f32+RD_BASE; no writes.
  - LW (001/00): alu 6; rs=f54+RS_BASE; rd=f32; reg_write, mem_read, mem2reg.
  - SW (001/01): alu 6; rs=f54+RS_BASE; rt=f32; mem_write; reg_write=0.
  - INC (001/10): alu 4; rs=rd=instr[5:2]; imm=1; sel_imm.
  - NOT (001/11): alu 3; rs=rd=instr[5:2].
  - ADD/SUB (010/100): alu 4/5; rs=f54+RS_BASE; rt=f32; rd=f10+RD_BASE; reg_write, car_write.
  - ADDI (011): alu 4; rs=f32; rd=f54+RD_BASE; imm=f10; sel_imm.
  - TR (101): alu 6; rs=instr[2:0]+5; rd=instr[5:3]+1; reg_write.
  - JR (110): alu 6; imm=instr[5:0]; jump.
  - SRL/SRA/SLL (111, sub 00/01/10): alu 8/9/10; rs=rd=f54+RS_BASE; rt=f32; reg_write, car_write.
  - HALT (111/11): all controls 0; enters HALTED when accepted.
- Address arithmetic: modulo 2^RA.
- Load-use hazard:
  - Condition: out_valid & mem_read held, and the incoming instruction reads rs or rt equal to the held rd.
  - Effect: in_ready=0 until the LW bundle is consumed. Then one bubble cycle (out_valid=0) before the dependent instruction is accepted.
- Flush:
  - Clears out_valid next cycle and drops any instruction accepted the same cycle.
  - Flush has priority over accept. Flush does not clear halted.
- HALT bundle:
  - out_valid=1 with halt-only bundle; halted=1 the cycle after acceptance.
  - resume and HALT acceptance in the same cycle: halt wins.
- Reset mid-operation: the bundle is discarded immediately.

Optional Feature:
- Macro DECODE_STAGE_STATS_EN.
- When defined: adds outputs retired_count [15:0] and stall_count [15:0].
  - retired_count increments on each out_valid & out_ready.
  - stall_count increments each cycle in_valid & !in_ready & !halted.
  - Both saturate at 16'hFFFF and reset to 0.
- When undefined: ports and counters are absent; behaviour otherwise identical.

Test Plan:
- ADD 9'b010_01_10_11 accepted, out_ready=1 -> next cycle: out_valid=1, alu_op=4, rs=5, rt=2, rd=11, reg_write=1, car_write=1.
- LW 9'b001_00_01_00, then AND reading rt=1, out_ready=1 -> one bubble, AND bundle appears two cycles after LW bundle.
- out_ready=0 for 3 cycles with a valid bundle -> bundle stable, in_ready=0; out_ready=1 -> consumed, in_ready=1.
- HALT 9'b111_000011 -> halted=1, in_ready=0 for 10 cycles; resume pulse -> in_ready=1 next cycle.
- flush asserted in the same cycle as acceptance of INC -> out_valid=0 next cycle, no INC bundle emitted.
- rst_n low mid-stall -> all outputs 0 asynchronously; first instruction after release decodes normally.
